usb3_tx_framer: RTL

Upstream packet framer and FX3 slave-FIFO write master. It accepts 32-bit sample words from FPGA logic and buffers them. It frames them into packets, each a typed header word followed by payload, and drives the USB3 (FX3) slave-FIFO write pins. It is the transmit-direction counterpart of the USB3 receive / RAM-cache path, and it emits the same header format that path decodes.

---
 rtl/usb3_tx_framer_pkg.sv | 31 +++
 rtl/sync_fwft_fifo.sv | 52 +++++
 rtl/usb3_tx_framer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/usb3_tx_framer_pkg.sv
// rtl/usb3_tx_framer_pkg.sv - shared USB3 framing constants: state codes, header mark, type codes
package usb3_tx_framer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_HDR     = 4'd1,
    ST_PAYLOAD = 4'd2,
    ST_GAP     = 4'd3
  } wr_state_t;

  localparam logic [7:0]  HDR_MARK    = 8'hFF;
  localparam logic [15:0] TYPE_CODE_1 = 16'h0000;
  localparam logic [15:0] TYPE_CODE_2 = 16'h000A;
  localparam logic [15:0] TYPE_CODE_3 = 16'h00AA;
  localparam logic [15:0] TYPE_CODE_4 = 16'h0AAA;
  localparam logic [15:0] TYPE_CODE_5 = 16'hAAAA;

  // Unassigned types (0, 6, 7) share the type-1 code so the receiver never sees an unknown header.
  function automatic logic [31:0] header_word(input logic [2:0] ptype);
    logic [15:0] code;
    case (ptype)
      3'd2:    code = TYPE_CODE_2;
      3'd3:    code = TYPE_CODE_3;
      3'd4:    code = TYPE_CODE_4;
      3'd5:    code = TYPE_CODE_5;
      default: code = TYPE_CODE_1;
    endcase
    return {HDR_MARK, code, HDR_MARK};
  endfunction

endpackage

// File: rtl/sync_fwft_fifo.sv
// rtl/sync_fwft_fifo.sv - single-clock first-word-fall-through FIFO with occupancy count
module sync_fwft_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic                     wrclock,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge wrclock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge wrclock) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/usb3_tx_framer.sv
// rtl/usb3_tx_framer.sv - packet framer and FX3 slave-FIFO write master
module usb3_tx_framer
  import usb3_tx_framer_pkg::*;
#(
  parameter int PKT_WORDS  = 254,
  parameter int FIFO_DEPTH = 256,
  parameter int GAP_CYCLES = 3
) (
  input  logic        wrclock,
  input  logic        rst_n,
  input  logic [31:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [2:0]  pkt_type,
  input  logic        flush,
  input  logic        USB3_FLAGB,
  output logic [31:0] USB3_DQ,
  output logic        USB3_SLWR_N,
  output logic        USB3_PKTEND_N,
  output logic [3:0]  usb_wr_state,
  output logic [15:0] pkt_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] PKT_LEN  = CW'(PKT_WORDS);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  wr_state_t     state;
  logic [CW-1:0] words_left;
  logic [GW-1:0] gap_cnt;
  logic          short_pkt;
  logic          flush_latch;

  logic [31:0]   fifo_head;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_next;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          start_full;
  logic          start_short;

  assign push = din_valid && din_ready && !fifo_full;
  assign pop  = (state == ST_HDR) || ((state == ST_PAYLOAD) && (words_left != '0));

  assign start_full  = USB3_FLAGB && (fifo_count >= PKT_LEN);
  assign start_short = USB3_FLAGB && flush_latch && (fifo_count != '0) && (fifo_count < PKT_LEN);

  assign usb_wr_state = state;

  // din_ready is registered, so it is derived from the occupancy the FIFO will have after this edge.
  always_comb begin
    count_next = fifo_count;
    if (push && !pop)      count_next = fifo_count + CW'(1);
    else if (pop && !push) count_next = fifo_count - CW'(1);
  end

  sync_fwft_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .wrclock   (wrclock),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (din),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge wrclock) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      USB3_DQ       <= '0;
      USB3_SLWR_N   <= 1'b1;
      USB3_PKTEND_N <= 1'b1;
      words_left    <= '0;
      gap_cnt       <= '0;
      short_pkt     <= 1'b0;
      flush_latch   <= 1'b0;
      pkt_count     <= '0;
      din_ready     <= 1'b0;
    end else begin
      din_ready <= (count_next != DEPTH_C);
      case (state)
        ST_IDLE: begin
          USB3_SLWR_N   <= 1'b1;
          USB3_PKTEND_N <= 1'b1;
          if (start_full) begin
            state       <= ST_HDR;
            USB3_DQ     <= header_word(pkt_type);
            USB3_SLWR_N <= 1'b0;
            words_left  <= PKT_LEN;
            short_pkt   <= 1'b0;
            if (fifo_count == PKT_LEN) flush_latch <= 1'b0;
          end else if (start_short) begin
            state       <= ST_HDR;
            USB3_DQ     <= header_word(pkt_type);
            USB3_SLWR_N <= 1'b0;
            words_left  <= fifo_count;
            short_pkt   <= 1'b1;
            flush_latch <= 1'b0;
          end
        end
        ST_HDR: begin
          state         <= ST_PAYLOAD;
          USB3_DQ       <= fifo_head;
          USB3_SLWR_N   <= 1'b0;
          USB3_PKTEND_N <= !(short_pkt && (words_left == CW'(1)));
          words_left    <= words_left - CW'(1);
        end
        ST_PAYLOAD: begin
          if (words_left != '0) begin
            USB3_DQ       <= fifo_head;
            USB3_PKTEND_N <= !(short_pkt && (words_left == CW'(1)));
            words_left    <= words_left - CW'(1);
          end else begin
            state         <= ST_GAP;
            USB3_SLWR_N   <= 1'b1;
            USB3_PKTEND_N <= 1'b1;
            pkt_count     <= pkt_count + 16'd1;
            gap_cnt       <= GAP_LAST;
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) state <= ST_IDLE;
          else               gap_cnt <= gap_cnt - GW'(1);
        end
        default: state <= ST_IDLE;
      endcase
      // A flush pulse overrides any clear above; on an empty FIFO it leaves nothing pending.
      if (flush) flush_latch <= !fifo_empty;
    end
  end

endmodule
